psg_bus_sequencer: RTL

PSG_BUS_SEQUENCER -- requirements
Module: psg_bus_sequencer

---
 rtl/psg_bus_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/psg_bus_sequencer.sv
// psg_bus_sequencer: round-robin arbiter for two write requesters driving a PSG BDIR/BC bus,
// skipping the address phase when the chip/register matches the last address written.
module psg_bus_sequencer #(
  parameter int PULSE = 2,
  parameter int GAP = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       a_req,
  input  logic       a_chip,
  input  logic [3:0] a_reg,
  input  logic [7:0] a_data,
  output logic       a_ack,
  input  logic       b_req,
  input  logic       b_chip,
  input  logic [3:0] b_reg,
  input  logic [7:0] b_data,
  output logic       b_ack,
  output logic       psg_sel,
  output logic       psg_bdir,
  output logic       psg_bc,
  output logic [7:0] psg_di,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_t;
  localparam logic [3:0] P1 = 4'(PULSE - 1);
  localparam logic [3:0] G1 = 4'(GAP - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic chip_q, chip_d;
  logic [3:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic sh_v_q, sh_v_d, sh_chip_q, sh_chip_d;
  logic [3:0] sh_reg_q, sh_reg_d;
  logic last_b_q, last_b_d;
  logic a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic bdir_q, bc_q, busy_q;
  logic [7:0] di_q, di_d;
  logic grant_b;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - 4'd1;
    chip_d = chip_q;
    reg_d = reg_q;
    data_d = data_q;
    sh_v_d = sh_v_q;
    sh_chip_d = sh_chip_q;
    sh_reg_d = sh_reg_q;
    last_b_d = last_b_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    grant_b = b_req & (~a_req | ~last_b_q);
    case (state_q)
      IDLE: if (a_req | b_req) begin
        chip_d = grant_b ? b_chip : a_chip;
        reg_d = grant_b ? b_reg : a_reg;
        data_d = grant_b ? b_data : a_data;
        a_ack_d = ~grant_b;
        b_ack_d = grant_b;
        last_b_d = grant_b;
        state_d = (sh_v_q && sh_chip_q == chip_d && sh_reg_q == reg_d) ? DATA : ADDR;
        cnt_d = P1;
      end
      ADDR: if (cnt_q == 4'd0) begin
        state_d = GAP1;
        cnt_d = G1;
        sh_v_d = 1'b1;
        sh_chip_d = chip_q;
        sh_reg_d = reg_q;
      end
      GAP1: if (cnt_q == 4'd0) begin
        state_d = DATA;
        cnt_d = P1;
      end
      DATA: if (cnt_q == 4'd0) begin
        state_d = GAP2;
        cnt_d = G1;
      end
      GAP2: if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // bus data follows the phase being entered and holds through gaps and idle
    di_d = (state_d == ADDR) ? {4'b0000, reg_d} : (state_d == DATA) ? data_d : di_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      chip_q <= 1'b0;
      reg_q <= 4'd0;
      data_q <= 8'd0;
      sh_v_q <= 1'b0;
      sh_chip_q <= 1'b0;
      sh_reg_q <= 4'd0;
      last_b_q <= 1'b1;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      bdir_q <= 1'b0;
      bc_q <= 1'b0;
      busy_q <= 1'b0;
      di_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      chip_q <= chip_d;
      reg_q <= reg_d;
      data_q <= data_d;
      sh_v_q <= sh_v_d;
      sh_chip_q <= sh_chip_d;
      sh_reg_q <= sh_reg_d;
      last_b_q <= last_b_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      bdir_q <= state_d == ADDR || state_d == DATA;
      bc_q <= state_d == ADDR;
      busy_q <= state_d != IDLE;
      di_q <= di_d;
    end
  end
  assign a_ack = a_ack_q;
  assign b_ack = b_ack_q;
  assign psg_sel = chip_q;
  assign psg_bdir = bdir_q;
  assign psg_bc = bc_q;
  assign psg_di = di_q;
  assign busy = busy_q;
endmodule
